// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vram_pkg
//  Description : Shared VRAM map constants, write-buffer entry type and the
//                address range helper used by vram_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package vram_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int BUS_ADDR_W     = 24;
    localparam int DATA_W         = 16;
    localparam int BE_W           = 2;

    localparam logic [BUS_ADDR_W-1:0] BG0_BASE     = 24'h00_0000;
    localparam logic [BUS_ADDR_W-1:0] BG1_BASE     = 24'h00_1000;
    localparam logic [BUS_ADDR_W-1:0] BG2_BASE     = 24'h00_2000;
    localparam logic [BUS_ADDR_W-1:0] BG3_BASE     = 24'h00_3000;
    localparam logic [BUS_ADDR_W-1:0] PATTERN_BASE = 24'h00_4000;
    localparam logic [BUS_ADDR_W-1:0] SPRITE_BASE  = 24'h00_8000;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic [BE_W-1:0]       be;
    } wbuf_entry_t;

    // An address is backed by the array only when every bit above addr_w is zero.
    function automatic logic addr_in_range(input logic [BUS_ADDR_W-1:0] addr,
                                           input int unsigned addr_w);
        return (addr >> addr_w) == '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_bram.sv
`default_nettype none
// ============================================================================
//  Module      : vram_bram
//  Description : Single-port byte-enabled RAM, registered address stage plus
//                registered output stage (2-cycle read latency, read-first).
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_bram #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int BE_W   = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int LANE_W = DATA_W / BE_W;

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_q1;
    logic [DATA_W-1:0] r_q2;

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (we && be[i]) begin
                r_mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
        end
        r_q1 <= r_mem[addr];
        r_q2 <= r_q1;
    end

    assign rdata = r_q2;

endmodule
`default_nettype wire

// File: rtl/vram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vram_ctrl
//  Description : VRAM responder: PPU port with strict priority, CPU port with a
//                one-entry posted write buffer, and a saturating stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_ctrl
    import vram_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [BUS_ADDR_W-1:0] ppu_addr,
    input  logic [DATA_W-1:0]     ppu_wdata,
    input  logic                  ppu_we,
    input  logic                  ppu_re,
    output logic [DATA_W-1:0]     ppu_rdata,
    output logic                  ppu_rvalid,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [BUS_ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [BE_W-1:0]       cpu_be,
    output logic                  cpu_ready,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_rvalid,
    output logic [CNT_W-1:0]      stall_cnt,
    input  logic                  stall_clr
);

    logic              w_ppu_access;
    logic              w_ppu_read;
    logic              w_ppu_in_range;
    logic              w_cpu_in_range;
    logic              w_wbuf_in_range;
    logic              w_cpu_rd_inflight;
    logic              w_cpu_rd_acc;
    logic              w_cpu_wr_acc;
    logic              w_drain;
    logic              w_stall;

    logic              r_wbuf_full;
    wbuf_entry_t       r_wbuf;

    logic              w_mem_we;
    logic [BE_W-1:0]   w_mem_be;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_mem_rdata;
    logic [DATA_W-1:0] w_rd_value;

    logic              r_s1_ppu, r_s1_cpu, r_s1_zero;
    logic              r_s2_ppu, r_s2_cpu, r_s2_zero;
    logic [DATA_W-1:0] r_ppu_hold;
    logic [DATA_W-1:0] r_cpu_hold;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_ppu_access      = ppu_re || ppu_we;
    assign w_ppu_read        = ppu_re && !ppu_we;
    assign w_ppu_in_range    = addr_in_range(ppu_addr, ADDR_W);
    assign w_cpu_in_range    = addr_in_range(cpu_addr, ADDR_W);
    assign w_wbuf_in_range   = addr_in_range(r_wbuf.addr, ADDR_W);
    assign w_cpu_rd_inflight = r_s1_cpu || r_s2_cpu;

    // Reads wait for an empty buffer so program order holds without forwarding.
    assign cpu_ready    = cpu_we ? !r_wbuf_full
                                 : (!r_wbuf_full && !w_ppu_access && !w_cpu_rd_inflight);
    assign w_cpu_rd_acc = cpu_req && !cpu_we && cpu_ready;
    assign w_cpu_wr_acc = cpu_req &&  cpu_we && cpu_ready;
    assign w_drain      = r_wbuf_full && !w_ppu_access;
    assign w_stall      = cpu_req && !cpu_ready;

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_be    = '1;
        w_mem_addr  = cpu_addr[ADDR_W-1:0];
        w_mem_wdata = ppu_wdata;
        if (w_ppu_access) begin
            w_mem_addr = ppu_addr[ADDR_W-1:0];
            w_mem_we   = ppu_we && w_ppu_in_range;
        end else if (w_drain) begin
            w_mem_addr  = r_wbuf.addr[ADDR_W-1:0];
            w_mem_we    = w_wbuf_in_range;
            w_mem_be    = r_wbuf.be;
            w_mem_wdata = r_wbuf.data;
        end
    end

    vram_bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BE_W   (BE_W)
    ) u_bram (
        .clk   (clk),
        .we    (w_mem_we),
        .be    (w_mem_be),
        .addr  (w_mem_addr),
        .wdata (w_mem_wdata),
        .rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wbuf_full <= 1'b0;
            r_wbuf      <= '0;
        end else if (w_cpu_wr_acc) begin
            r_wbuf_full <= 1'b1;
            r_wbuf      <= '{addr: cpu_addr, data: cpu_wdata, be: cpu_be};
        end else if (w_drain) begin
            r_wbuf_full <= 1'b0;
        end
    end

    // Read tags travel alongside the array pipeline; zero flags out-of-range reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_ppu   <= 1'b0;
            r_s1_cpu   <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s2_ppu   <= 1'b0;
            r_s2_cpu   <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_ppu_hold <= '0;
            r_cpu_hold <= '0;
        end else begin
            r_s1_ppu  <= w_ppu_read;
            r_s1_cpu  <= w_cpu_rd_acc;
            r_s1_zero <= w_ppu_access ? !w_ppu_in_range : !w_cpu_in_range;
            r_s2_ppu  <= r_s1_ppu;
            r_s2_cpu  <= r_s1_cpu;
            r_s2_zero <= r_s1_zero;
            if (r_s2_ppu) r_ppu_hold <= w_rd_value;
            if (r_s2_cpu) r_cpu_hold <= w_rd_value;
        end
    end

    assign w_rd_value = r_s2_zero ? '0 : w_mem_rdata;
    assign ppu_rvalid = r_s2_ppu;
    assign cpu_rvalid = r_s2_cpu;
    assign ppu_rdata  = r_s2_ppu ? w_rd_value : r_ppu_hold;
    assign cpu_rdata  = r_s2_cpu ? w_rd_value : r_cpu_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (stall_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_ctrl
//  Description : Scoreboard bench for vram_ctrl (PPU/CPU reads, posted writes,
//                byte enables, range checks, stall counter, reset mid-flight).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_ctrl;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] ppu_addr;
    logic [15:0] ppu_wdata;
    logic        ppu_we;
    logic        ppu_re;
    logic [15:0] ppu_rdata;
    logic        ppu_rvalid;
    logic        cpu_req;
    logic        cpu_we;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [1:0]  cpu_be;
    logic        cpu_ready;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic [CNT_W-1:0] stall_cnt;
    logic        stall_clr;

    always #5 clk = ~clk;

    vram_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ppu_addr   (ppu_addr),
        .ppu_wdata  (ppu_wdata),
        .ppu_we     (ppu_we),
        .ppu_re     (ppu_re),
        .ppu_rdata  (ppu_rdata),
        .ppu_rvalid (ppu_rvalid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_be     (cpu_be),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .stall_cnt  (stall_cnt),
        .stall_clr  (stall_clr)
    );

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        ppu_q[$];
    exp_t        cpu_q[$];
    exp_t        pe;
    exp_t        ce;
    logic [15:0] ppu_exp;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every rvalid must match the oldest outstanding read, two cycles after issue.
    always @(negedge clk) begin
        if (reset_n && ppu_rvalid) begin
            n_tests++;
            if (ppu_q.size() == 0) begin
                n_fail++;
                $display("FAIL ppu_rvalid_unexpected: got rvalid with data %h, required no rvalid", ppu_rdata);
            end else begin
                pe = ppu_q.pop_front();
                if (ppu_rdata !== pe.data || (cyc - pe.cyc) != 2) begin
                    n_fail++;
                    $display("FAIL ppu_read: got %h latency %0d, required %h latency 2",
                             ppu_rdata, cyc - pe.cyc, pe.data);
                end
            end
        end
        if (reset_n && cpu_rvalid) begin
            n_tests++;
            if (cpu_q.size() == 0) begin
                n_fail++;
                $display("FAIL cpu_rvalid_unexpected: got rvalid with data %h, required no rvalid", cpu_rdata);
            end else begin
                ce = cpu_q.pop_front();
                if (cpu_rdata !== ce.data || (cyc - ce.cyc) != 2) begin
                    n_fail++;
                    $display("FAIL cpu_read: got %h latency %0d, required %h latency 2",
                             cpu_rdata, cyc - ce.cyc, ce.data);
                end
            end
        end
    end

    task automatic idle_inputs();
        ppu_re = 1'b0; ppu_we = 1'b0; ppu_addr = '0; ppu_wdata = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        stall_clr = 1'b0;
    endtask

    // Commits the current input cycle; a pure PPU read registers its expectation.
    task automatic tick();
        if (ppu_re && !ppu_we) ppu_q.push_back('{ppu_exp, cyc});
        @(posedge clk);
        #1;
    endtask

    task automatic ppu_write(input logic [23:0] a, input logic [15:0] d);
        ppu_re = 1'b0; ppu_we = 1'b1; ppu_addr = a; ppu_wdata = d;
        tick();
        ppu_we = 1'b0;
    endtask

    task automatic ppu_read(input logic [23:0] a, input logic [15:0] e);
        ppu_re = 1'b1; ppu_we = 1'b0; ppu_addr = a; ppu_exp = e;
        tick();
        ppu_re = 1'b0;
    endtask

    task automatic cpu_write(input logic [23:0] a, input logic [15:0] d, input logic [1:0] be);
        bit ok = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_be = be;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (cpu_ready) ok = 1'b1;
            else tick();
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cpu_write_accept: got no ready in 20 cycles, required acceptance");
        end
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [23:0] a, input logic [15:0] e);
        bit ok = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (cpu_ready) ok = 1'b1;
            else tick();
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cpu_read_accept: got no ready in 20 cycles, required acceptance");
        end else begin
            cpu_q.push_back('{e, cyc});
        end
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic wait_idle();
        idle_inputs();
        for (int i = 0; i < 20 && (ppu_q.size() != 0 || cpu_q.size() != 0); i++) tick();
        n_tests++;
        if (ppu_q.size() != 0 || cpu_q.size() != 0) begin
            n_fail++;
            $display("FAIL reads_outstanding: got %0d ppu / %0d cpu pending, required 0 / 0",
                     ppu_q.size(), cpu_q.size());
            ppu_q.delete();
            cpu_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        n_tests += 5;
        if (ppu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_ppu_rvalid: got %b, required 0", ppu_rvalid); end
        if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_rvalid: got %b, required 0", cpu_rvalid); end
        if (ppu_rdata !== 16'h0) begin n_fail++; $display("FAIL rst_ppu_rdata: got %h, required 0000", ppu_rdata); end
        if (cpu_rdata !== 16'h0) begin n_fail++; $display("FAIL rst_cpu_rdata: got %h, required 0000", cpu_rdata); end
        if (stall_cnt !== '0) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d, required 0", stall_cnt); end
        reset_n = 1'b1;
        ppu_we = 1'b1; ppu_addr = 24'h7000;
        #1;
        n_tests++;
        if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_rd_ppu: got %b, required 0", cpu_ready); end
        cpu_we = 1'b1;
        #1;
        n_tests++;
        if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_wr: got %b, required 1", cpu_ready); end
        ppu_we = 1'b0; cpu_we = 1'b0;
        #1;
        n_tests++;
        if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rd_idle: got %b, required 1", cpu_ready); end
        tick();
    endtask

    task automatic test_ppu_rw();
        for (int i = 1; i < 8; i++) ppu_write(24'h4000 + 24'(i), 16'hC000 + 16'(i));
        ppu_write(24'h4000, 16'hBEEF);
        ppu_read(24'h4000, 16'hBEEF);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        for (int i = 0; i < 8; i++) begin
            e = (i == 0) ? 16'hBEEF : 16'hC000 + 16'(i);
            ppu_re = 1'b1; ppu_we = 1'b0; ppu_addr = 24'h4000 + 24'(i); ppu_exp = e;
            tick();
        end
        wait_idle();
        n_tests++;
        if (ppu_rvalid !== 1'b0 || ppu_rdata !== 16'hC007) begin
            n_fail++;
            $display("FAIL ppu_rdata_hold: got rvalid %b data %h, required 0 / c007", ppu_rvalid, ppu_rdata);
        end
    endtask

    task automatic test_posted_write();
        ppu_re = 1'b1; ppu_addr = 24'h4000; ppu_exp = 16'hBEEF;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h1234; cpu_wdata = 16'hA55A; cpu_be = 2'b11;
        #1;
        n_tests++;
        if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL posted_accept: got %b, required 1", cpu_ready); end
        tick();
        cpu_addr = 24'h1235; cpu_wdata = 16'h0F0F;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL posted_stall_%0d: got %b, required 0", i, cpu_ready); end
            tick();
        end
        ppu_re = 1'b0;
        #1;
        n_tests++;
        if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL posted_drain_cycle: got %b, required 0", cpu_ready); end
        tick();
        ppu_re = 1'b1;
        #1;
        n_tests++;
        if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL posted_after_drain: got %b, required 1", cpu_ready); end
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        tick();
        wait_idle();
        cpu_read(24'h1234, 16'hA55A);
        cpu_read(24'h1235, 16'h0F0F);
        wait_idle();
    endtask

    task automatic test_byte_enable();
        ppu_write(24'h0010, 16'h1122);
        cpu_write(24'h0010, 16'hFF00, 2'b10);
        cpu_read(24'h0010, 16'hFF22);
        cpu_write(24'h0010, 16'h0033, 2'b01);
        cpu_read(24'h0010, 16'hFF33);
        wait_idle();
        n_tests++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'hFF33) begin
            n_fail++;
            $display("FAIL cpu_rdata_hold: got rvalid %b data %h, required 0 / ff33", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_oor_simul();
        ppu_write(24'h0020, 16'h5555);
        ppu_write(24'h01_0020, 16'hDEAD);
        ppu_read(24'h01_0020, 16'h0000);
        ppu_read(24'h0020, 16'h5555);
        wait_idle();
        ppu_re = 1'b1; ppu_we = 1'b1; ppu_addr = 24'h0030; ppu_wdata = 16'h7777;
        tick();
        idle_inputs();
        tick();
        n_tests++;
        if (ppu_rvalid !== 1'b0) begin n_fail++; $display("FAIL simul_no_rvalid: got %b, required 0", ppu_rvalid); end
        ppu_read(24'h0030, 16'h7777);
        cpu_read(24'h80_0020, 16'h0000);
        cpu_write(24'h01_0020, 16'hBAD0, 2'b11);
        cpu_read(24'h0020, 16'h5555);
        wait_idle();
    endtask

    task automatic test_stall_cnt();
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        n_tests++;
        if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL stall_clear_idle: got %0d, required 0", stall_cnt); end
        ppu_re = 1'b1; ppu_addr = 24'h4000; ppu_exp = 16'hBEEF;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h1234;
        repeat (5) tick();
        ppu_re = 1'b0;
        #1;
        n_tests++;
        if (cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_read_accept: got %b, required 1", cpu_ready);
        end else begin
            cpu_q.push_back('{16'hA55A, cyc});
        end
        tick();
        cpu_req = 1'b0;
        n_tests++;
        if (stall_cnt !== 4'd5) begin n_fail++; $display("FAIL stall_count_5: got %0d, required 5", stall_cnt); end
        wait_idle();
        ppu_re = 1'b1; ppu_addr = 24'h4000; ppu_exp = 16'hBEEF;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h1234;
        repeat (20) tick();
        n_tests++;
        if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL stall_saturate: got %0d, required 15", stall_cnt); end
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        n_tests++;
        if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL stall_clr_wins: got %0d, required 0", stall_cnt); end
        tick();
        n_tests++;
        if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL stall_after_clr: got %0d, required 1", stall_cnt); end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        ppu_write(24'h0050, 16'h1111);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h0050;
        #1;
        n_tests++;
        if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL mid_read_accept: got %b, required 1", cpu_ready); end
        tick();
        cpu_we = 1'b1; cpu_wdata = 16'h2222; cpu_be = 2'b11;
        #1;
        n_tests++;
        if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL mid_write_accept: got %b, required 1", cpu_ready); end
        tick();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cpu_we = 1'b1;
        #1;
        n_tests++;
        if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL mid_wbuf_empty: got ready %b, required 1", cpu_ready); end
        cpu_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rvalid_%0d: got %b, required 0", i, cpu_rvalid); end
        end
        n_tests++;
        if (cpu_rdata !== 16'h0) begin n_fail++; $display("FAIL mid_rdata_reset: got %h, required 0000", cpu_rdata); end
        cpu_read(24'h0050, 16'h1111);
        wait_idle();
    endtask

    initial begin
        idle_inputs();
        ppu_exp = '0;
        test_reset();
        test_ppu_rw();
        test_back_to_back();
        test_posted_write();
        test_byte_enable();
        test_oor_simul();
        test_stall_cnt();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 ns, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
